// File: rtl/wbm_arbiter_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Holds the FSM encoding, one-hot grant values and bus widths.
package wbm_arbiter_pkg;
  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;
  localparam int WB_SEL_W  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GNT_IF  = 2'd1,
    ARB_GNT_MEM = 2'd2,
    ARB_ABORT   = 2'd3
  } arb_state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IF   = 2'b01;
  localparam logic [1:0] GRANT_MEM  = 2'b10;

  // A zero timeout still needs a 1-bit counter to keep the vector legal.
  function automatic int unsigned wd_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction
endpackage

// File: rtl/arb_watchdog.sv
// Counts unacknowledged strobe cycles and flags expiry when the count reaches TIMEOUT_CYCLES.
// Expiry is combinational from the count register; clear has priority over enable; no backpressure.
module arb_watchdog
  import wbm_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);
  localparam int unsigned CNT_W = wd_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign expire_o = (TIMEOUT_CYCLES != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/wbm_arbiter.sv
// Round-robin arbiter giving fetch or memory stage the outbound Wishbone bus per cyc, with abort watchdog.
// Grant one cycle after cyc is sampled, zero-gap handoff; ack/err routed combinationally; losers simply wait.
module wbm_arbiter
  import wbm_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 if_cyc_i,
  input  logic                 if_stb_i,
  input  logic                 if_we_i,
  input  logic [WB_SEL_W-1:0]  if_sel_i,
  input  logic [WB_ADDR_W-1:0] if_addr_i,
  input  logic [WB_DATA_W-1:0] if_dat_i,
  output logic                 if_ack_o,
  output logic                 if_err_o,
  output logic [WB_DATA_W-1:0] if_dat_o,
  input  logic                 mem_cyc_i,
  input  logic                 mem_stb_i,
  input  logic                 mem_we_i,
  input  logic [WB_SEL_W-1:0]  mem_sel_i,
  input  logic [WB_ADDR_W-1:0] mem_addr_i,
  input  logic [WB_DATA_W-1:0] mem_dat_i,
  output logic                 mem_ack_o,
  output logic                 mem_err_o,
  output logic [WB_DATA_W-1:0] mem_dat_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [WB_SEL_W-1:0]  wbm_sel_o,
  output logic [WB_ADDR_W-1:0] wbm_addr_o,
  output logic [WB_DATA_W-1:0] wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  input  logic [WB_DATA_W-1:0] wbm_dat_i,
  output logic [1:0]           grant_o
);
  arb_state_t state_q, state_d;
  logic       last_mem_q;
  logic [1:0] owner_q;
  logic       in_gnt, resp, wd_en, wd_clr, expire;

  assign resp   = wbm_ack_i | wbm_err_i;
  assign in_gnt = (state_q == ARB_GNT_IF) || (state_q == ARB_GNT_MEM);
  assign wd_en  = in_gnt && wbm_stb_o && !resp;
  assign wd_clr = resp || !in_gnt || (state_d != state_q);

  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (wd_en),
    .clr_i    (wd_clr),
    .expire_o (expire)
  );

  // owner_q trails the GNT state by a cycle so ABORT knows whom to blame.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ARB_IDLE;
      last_mem_q <= 1'b0;
      owner_q    <= GRANT_NONE;
    end else begin
      state_q <= state_d;
      if (state_d == ARB_GNT_IF)       last_mem_q <= 1'b0;
      else if (state_d == ARB_GNT_MEM) last_mem_q <= 1'b1;
      if (state_q == ARB_GNT_IF)       owner_q <= GRANT_IF;
      else if (state_q == ARB_GNT_MEM) owner_q <= GRANT_MEM;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: begin
        if (if_cyc_i && mem_cyc_i) state_d = last_mem_q ? ARB_GNT_IF : ARB_GNT_MEM;
        else if (if_cyc_i)         state_d = ARB_GNT_IF;
        else if (mem_cyc_i)        state_d = ARB_GNT_MEM;
      end
      ARB_GNT_IF: begin
        if (!if_cyc_i)             state_d = mem_cyc_i ? ARB_GNT_MEM : ARB_IDLE;
        else if (expire && !resp)  state_d = ARB_ABORT;
      end
      ARB_GNT_MEM: begin
        if (!mem_cyc_i)            state_d = if_cyc_i ? ARB_GNT_IF : ARB_IDLE;
        else if (expire && !resp)  state_d = ARB_ABORT;
      end
      default:                     state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    wbm_we_o   = 1'b0;
    wbm_sel_o  = '0;
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    if_ack_o   = 1'b0;
    if_err_o   = 1'b0;
    mem_ack_o  = 1'b0;
    mem_err_o  = 1'b0;
    grant_o    = GRANT_NONE;
    case (state_q)
      ARB_GNT_IF: begin
        wbm_cyc_o  = if_cyc_i;
        wbm_stb_o  = if_stb_i;
        wbm_we_o   = if_we_i;
        wbm_sel_o  = if_sel_i;
        wbm_addr_o = if_addr_i;
        wbm_dat_o  = if_dat_i;
        if_ack_o   = wbm_ack_i;
        if_err_o   = wbm_err_i;
        grant_o    = GRANT_IF;
      end
      ARB_GNT_MEM: begin
        wbm_cyc_o  = mem_cyc_i;
        wbm_stb_o  = mem_stb_i;
        wbm_we_o   = mem_we_i;
        wbm_sel_o  = mem_sel_i;
        wbm_addr_o = mem_addr_i;
        wbm_dat_o  = mem_dat_i;
        mem_ack_o  = wbm_ack_i;
        mem_err_o  = wbm_err_i;
        grant_o    = GRANT_MEM;
      end
      ARB_ABORT: begin
        // A late slave ack is deliberately not forwarded here.
        if_err_o  = owner_q[0];
        mem_err_o = owner_q[1];
        grant_o   = owner_q;
      end
      default: ;
    endcase
  end

  assign if_dat_o  = wbm_dat_i;
  assign mem_dat_o = wbm_dat_i;
endmodule

// File: tb/tb_wbm_arbiter.sv
// Scoreboard bench for wbm_arbiter: stimulus predicts grant order and responses, a monitor checks them.
module tb_wbm_arbiter;
  localparam logic [1:0] G_IF  = 2'b01;
  localparam logic [1:0] G_MEM = 2'b10;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        if_cyc_i, if_stb_i, if_we_i, mem_cyc_i, mem_stb_i, mem_we_i;
  logic [3:0]  if_sel_i, mem_sel_i, wbm_sel_o;
  logic [31:0] if_addr_i, if_dat_i, mem_addr_i, mem_dat_i;
  logic        if_ack_o, if_err_o, mem_ack_o, mem_err_o;
  logic [31:0] if_dat_o, mem_dat_o, wbm_addr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
  logic [1:0]  grant_o;

  typedef struct {
    logic [1:0]  owner;
    bit          err;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr, wdat, rdat;
  } exp_t;

  exp_t       tq[$];
  logic [1:0] gq[$];
  int         checks = 0, errors = 0;
  int         slave_lat = 0, wait_cnt = 0;
  bit         slave_mute = 0;
  bit         model_last_mem = 0;
  logic [1:0] prev_grant = 2'b00;

  always #5 clk = ~clk;

  wbm_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_cyc_i(if_cyc_i), .if_stb_i(if_stb_i), .if_we_i(if_we_i), .if_sel_i(if_sel_i),
    .if_addr_i(if_addr_i), .if_dat_i(if_dat_i), .if_ack_o(if_ack_o), .if_err_o(if_err_o),
    .if_dat_o(if_dat_o),
    .mem_cyc_i(mem_cyc_i), .mem_stb_i(mem_stb_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_dat_i(mem_dat_i), .mem_ack_o(mem_ack_o), .mem_err_o(mem_err_o),
    .mem_dat_o(mem_dat_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_addr_o(wbm_addr_o), .wbm_dat_o(wbm_dat_o), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
    .wbm_dat_i(wbm_dat_i), .grant_o(grant_o)
  );

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a ^ 32'h5A5A_C3C3) + 32'h0101_0101);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] owner, input logic we, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdat);
    exp_t e;
    e.owner = owner; e.err = 0; e.we = we; e.sel = sel;
    e.addr = addr; e.wdat = wdat; e.rdat = rd_data(addr);
    return e;
  endfunction

  function automatic exp_t rnd(input logic [1:0] owner);
    return mk(owner, 1'($urandom_range(0, 1)), 4'($urandom_range(1, 15)),
              $urandom() & 32'hFFFF_FFFC, $urandom());
  endfunction

  // Slave: acks slave_lat cycles after it first sees a strobe; evaluated after masters drive.
  initial begin
    wbm_ack_i = 0; wbm_err_i = 0; wbm_dat_i = 32'hCAFE_F00D;
    forever begin
      @(posedge clk); #2;
      wbm_ack_i = 0;
      if (wbm_cyc_o && wbm_stb_o && !slave_mute) begin
        if (wait_cnt >= slave_lat) begin
          wbm_ack_i = 1; wbm_dat_i = rd_data(wbm_addr_o); wait_cnt = 0;
        end else wait_cnt++;
      end else wait_cnt = 0;
    end
  end

  // Monitor: grant changes and every ack/err are matched against the predicted queues.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        if (grant_o !== prev_grant) begin
          if (gq.size() == 0) chk("grant_unexpected", grant_o, prev_grant);
          else chk("grant_seq", grant_o, gq.pop_front());
          prev_grant = grant_o;
        end
        if (if_ack_o || mem_ack_o || if_err_o || mem_err_o) begin
          if (tq.size() == 0) chk("resp_unexpected", {mem_err_o, if_err_o, mem_ack_o, if_ack_o}, 0);
          else begin
            e = tq.pop_front();
            if (e.err) begin
              chk("abort_err_owner", {mem_err_o, if_err_o}, e.owner);
              chk("abort_no_ack", {mem_ack_o, if_ack_o}, 0);
              chk("abort_bus_cyc", wbm_cyc_o, 0);
            end else begin
              chk("ack_owner", {mem_ack_o, if_ack_o}, e.owner);
              chk("ack_no_err", {mem_err_o, if_err_o}, 0);
              chk("bus_addr", wbm_addr_o, e.addr);
              chk("bus_we", wbm_we_o, e.we);
              chk("bus_sel", wbm_sel_o, e.sel);
              chk("bus_wdat", wbm_dat_o, e.wdat);
              chk("rdata", (e.owner == G_IF) ? if_dat_o : mem_dat_o, e.rdat);
            end
          end
        end
      end
    end
  end

  task automatic master(input int p, input exp_t e);
    if (p == 0) begin
      if_cyc_i = 1; if_stb_i = 1; if_we_i = e.we; if_sel_i = e.sel; if_addr_i = e.addr; if_dat_i = e.wdat;
    end else begin
      mem_cyc_i = 1; mem_stb_i = 1; mem_we_i = e.we; mem_sel_i = e.sel; mem_addr_i = e.addr; mem_dat_i = e.wdat;
    end
    for (int n = 0; n <= 40; n++) begin
      @(negedge clk);
      if ((p == 0) ? (if_ack_o || if_err_o) : (mem_ack_o || mem_err_o)) break;
      if (n == 40) begin
        checks++; errors++;
        $display("FAIL master_timeout port=%0d actual=no_response required=response", p);
      end
    end
    @(posedge clk); #1;
    if (p == 0) begin if_cyc_i = 0; if_stb_i = 0; end
    else begin mem_cyc_i = 0; mem_stb_i = 0; end
  endtask

  // Reference: a lone request wins; a tie goes to the port that did not own the bus last.
  task automatic round(input bit want_if, input bit want_mem, input int lat,
                       input exp_t e_if, input exp_t e_mem);
    slave_lat = lat;
    if (want_if && want_mem) begin
      if (model_last_mem) begin
        tq.push_back(e_if); tq.push_back(e_mem); gq.push_back(G_IF); gq.push_back(G_MEM);
        model_last_mem = 1;
      end else begin
        tq.push_back(e_mem); tq.push_back(e_if); gq.push_back(G_MEM); gq.push_back(G_IF);
        model_last_mem = 0;
      end
    end else if (want_if) begin
      tq.push_back(e_if); gq.push_back(G_IF); model_last_mem = 0;
    end else begin
      tq.push_back(e_mem); gq.push_back(G_MEM); model_last_mem = 1;
    end
    gq.push_back(2'b00);
    @(posedge clk); #1;
    fork
      if (want_if) master(0, e_if);
      if (want_mem) master(1, e_mem);
    join
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    exp_t ea, eb;
    rst_i = 1;
    if_cyc_i = 0; if_stb_i = 0; if_we_i = 0; if_sel_i = 0; if_addr_i = 0; if_dat_i = 0;
    mem_cyc_i = 0; mem_stb_i = 0; mem_we_i = 0; mem_sel_i = 0; mem_addr_i = 0; mem_dat_i = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
    chk("rst_addr_dat", wbm_addr_o | wbm_dat_o, 0);
    chk("rst_resp", {if_ack_o, if_err_o, mem_ack_o, mem_err_o}, 0);
    chk("rst_if_dat", if_dat_o, 32'hCAFE_F00D);
    chk("rst_mem_dat", mem_dat_o, 32'hCAFE_F00D);
    rst_i = 0;

    // Fetch read of 0x100, slave answers after 2 cycles.
    ea = mk(G_IF, 0, 4'hF, 32'h100, 32'h0);
    fork
      round(1, 0, 2, ea, ea);
      begin
        @(posedge clk); #1;
        @(negedge clk); chk("lat_c0_grant", grant_o, 2'b00);
        @(negedge clk); chk("lat_c1_grant", grant_o, G_IF); chk("lat_c1_cyc", wbm_cyc_o, 1);
        @(negedge clk); chk("lat_c2_ack", if_ack_o, 0);
        @(negedge clk); chk("lat_c3_ack", if_ack_o, 1); chk("lat_c3_memack", mem_ack_o, 0);
      end
    join

    // Ties: memory stage first after reset, then alternating ownership with no idle gap.
    for (int i = 0; i < 3; i++) round(1, 1, $urandom_range(0, 3), rnd(G_IF), rnd(G_MEM));

    // Memory-stage partial store while fetch is idle.
    eb = mk(G_MEM, 1, 4'b0011, 32'h200, 32'h1234_5678);
    round(0, 1, 1, eb, eb);

    // Ack arriving exactly when the watchdog count reaches its limit.
    eb = mk(G_MEM, 0, 4'hF, 32'h300, 32'h0);
    round(0, 1, 4, eb, eb);

    // Unanswered memory-stage strobe: abort 5 cycles after the bus strobe.
    slave_mute = 1;
    eb = mk(G_MEM, 0, 4'hF, 32'h400, 32'h0);
    eb.err = 1;
    tq.push_back(eb); gq.push_back(G_MEM); gq.push_back(2'b00);
    model_last_mem = 1;
    @(posedge clk); #1;
    mem_cyc_i = 1; mem_stb_i = 1; mem_addr_i = 32'h400; mem_sel_i = 4'hF; mem_we_i = 0;
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("abort_cyc_k%0d", k), wbm_cyc_o, (k >= 1 && k <= 5));
      chk($sformatf("abort_err_k%0d", k), mem_err_o, (k == 6));
    end
    @(posedge clk); #1;
    mem_cyc_i = 0; mem_stb_i = 0;
    @(negedge clk);
    chk("abort_back_idle", grant_o, 2'b00);
    chk("abort_err_one_cycle", mem_err_o, 0);
    slave_mute = 0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 30; i++) begin
      int pick;
      pick = $urandom_range(0, 2);
      round(pick != 1, pick != 0, $urandom_range(0, 3), rnd(G_IF), rnd(G_MEM));
    end

    // Reset in the middle of a fetch transfer.
    slave_mute = 1;
    gq.push_back(G_IF); gq.push_back(2'b00);
    @(posedge clk); #1;
    if_cyc_i = 1; if_stb_i = 1; if_addr_i = 32'h500; if_sel_i = 4'hF; if_we_i = 0;
    repeat (3) @(posedge clk);
    #3 rst_i = 1;
    #1;
    chk("midrst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
    chk("midrst_addr", wbm_addr_o, 0);
    chk("midrst_grant", grant_o, 0);
    chk("midrst_resp", {if_ack_o, if_err_o, mem_ack_o, mem_err_o}, 0);
    @(posedge clk); #1;
    if_cyc_i = 0; if_stb_i = 0;
    @(posedge clk); #1;
    rst_i = 0;
    slave_mute = 0;
    model_last_mem = 0;
    round(1, 1, 1, rnd(G_IF), rnd(G_MEM));

    repeat (4) @(posedge clk);
    chk("tq_drained", tq.size(), 0);
    chk("gq_drained", gq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wbm_arbiter.md
# wbm_arbiter

Two-master Wishbone arbiter sharing the core's single external bus between the instruction-fetch port and the memory-stage (load/store) port. It sits between the two per-stage Wishbone masters and the outbound `wbm_*` bus. It grants ownership per bus cycle (`cyc`) using round-robin. A watchdog aborts transfers the slave never acknowledges, so a stalled slave cannot hang the pipeline.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles of unacknowledged `stb` before abort; 0 disables the watchdog.
- `clk_i` in 1: system clock, all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `if_cyc_i`, `if_stb_i`, `if_we_i` in 1 each: fetch master cycle, strobe and write enable.
- `if_sel_i` in 4: fetch master byte select.
- `if_addr_i`, `if_dat_i` in 32 each: fetch master address and write data.
- `if_ack_o`, `if_err_o` out 1 each: fetch master acknowledge and error.
- `if_dat_o` out 32: fetch read data.
- `mem_cyc_i`, `mem_stb_i`, `mem_we_i`, `mem_sel_i`, `mem_addr_i`, `mem_dat_i`, `mem_ack_o`, `mem_err_o`, `mem_dat_o`: memory-stage master, same widths as the fetch port.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o` out 1 each: outbound bus control.
- `wbm_sel_o` out 4: outbound byte select.
- `wbm_addr_o`, `wbm_dat_o` out 32 each: outbound address and write data.
- `wbm_ack_i`, `wbm_err_i` in 1 each: slave acknowledge and error.
- `wbm_dat_i` in 32: slave read data.
- `grant_o` out 2: current owner, one-hot; bit0 = fetch, bit1 = mem, 00 = none.

## Operation
- States:
  - IDLE: no owner.
  - GNT_IF: fetch port owns the bus.
  - GNT_MEM: memory-stage port owns the bus.
  - ABORT: one-cycle watchdog abort.
- IDLE transitions:
  - Only one `cyc` high: grant that port.
  - Both `cyc` high: grant the port that is not `last` (round-robin).
  - `last` resets to fetch, so after reset the memory stage wins the first tie.
  - `last` updates on every grant.
- GNT_x transitions:
  - Stay while `x_cyc_i` is high.
  - When `x_cyc_i` is low at an edge: go directly to the other GNT if the other port's `cyc` is high, else to IDLE.
- Routing in GNT_x:
  - `wbm_cyc_o` = `x_cyc_i`, `wbm_stb_o` = `x_stb_i`.
  - `we`, `sel`, `addr` and `dat` are muxed from port x.
  - `x_ack_o` = `wbm_ack_i`, `x_err_o` = `wbm_err_i`.
  - The non-granted port's `ack` and `err` are 0.
- Routing in IDLE and ABORT: `wbm_cyc_o` = `wbm_stb_o` = 0 and all other `wbm_*` outputs are 0.
- `wbm_dat_i` is broadcast to both `if_dat_o` and `mem_dat_o`; it is only meaningful with that port's `ack`.
- Watchdog:
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
  - Increments each cycle in GNT_x with `wbm_stb_o` = 1 and `wbm_ack_i` = `wbm_err_i` = 0.
  - Clears on `ack`, on `err`, or on leaving GNT.
  - When the count equals `TIMEOUT_CYCLES`, the next state is ABORT.
- ABORT:
  - Lasts exactly one cycle, then IDLE.
  - `x_err_o` = 1 to the aborted owner, driven from a registered copy of the owner.
  - A late `wbm_ack_i` arriving in ABORT is dropped.
- A master still holding `cyc` after ABORT is re-arbitrated from IDLE as a new request.
- `grant_o` decodes the state; ABORT shows the aborted owner.

## Timing
- Reset values:
  - State IDLE, `last` = fetch, counter 0.
  - All `wbm_*` outputs 0, all `ack`/`err` outputs 0, `grant_o` = 00.
  - `dat` outputs follow `wbm_dat_i`.
- Arbitration latency: request `cyc` sampled high at edge N gives `wbm_cyc_o` in cycle N+1.
- Handoff between owners on `cyc` drop costs zero idle cycles: the old owner's `cyc` is low in the drop cycle, and the new owner drives the bus from the next cycle.
- Routing is combinational from the state register, so `ack` reaches the owner in the same cycle.
- Abort timing: with `stb` held and no response for `TIMEOUT_CYCLES` cycles, ABORT occupies cycle `TIMEOUT_CYCLES`+1 after `stb` rises, and `err` is high in that cycle.
- A slave `ack` and the counter reaching `TIMEOUT_CYCLES` in the same cycle: the `ack` wins and the counter clears.
- Asserting `rst_i` mid-transfer drops `wbm_cyc_o` immediately (asynchronously) and sends no `ack`/`err`.

## Structure
- Shared package holds:
  - State encoding `ARB_IDLE`/`ARB_GNT_IF`/`ARB_GNT_MEM`/`ARB_ABORT`.
  - `GRANT_IF`/`GRANT_MEM` one-hot constants.
  - The Wishbone bus widths (address 32, data 32, select 4).
- One sub-module, `arb_watchdog`: counter, clear/enable inputs, `expire_o` pulse, parameterised by `TIMEOUT_CYCLES`.
- The FSM and the output mux live in the top level.

## Test plan
- Reset, fetch `cyc`/`stb` read of 0x100, slave acks after 2 cycles with 0xDEADBEEF -> `grant_o` = 01 one cycle after request, `if_ack_o` pulses and `if_dat_o` = 0xDEADBEEF, `mem_ack_o` stays 0.
- Both ports request in the same cycle after reset -> mem granted first (`grant_o` = 10); on mem `cyc` drop, fetch is granted the next cycle with no IDLE gap.
- Three back-to-back simultaneous request pairs -> grants alternate mem, if, mem.
- Mem store with `sel` = 4'b0011 and `dat` = 0x12345678 while fetch is idle -> `wbm_we_o` = 1, `wbm_sel_o` = 0011, `wbm_dat_o` = 0x12345678; fetch `ack` and `err` stay 0.
- `TIMEOUT_CYCLES` = 4, slave never acks -> `mem_err_o` = 1 for exactly one cycle, 5 cycles after `stb`; `wbm_cyc_o` is 0 in that cycle; state returns to IDLE.
- `rst_i` asserted mid-transfer -> all outputs 0 before the next clock edge; the first tie after release goes to mem.
